// File: rtl/spatz_tcdm_amo_adapter_pkg.sv
// Shared TCDM request/response definitions: atomic opcode encoding and
// the bank adapter state type.
package spatz_tcdm_amo_adapter_pkg;

  typedef enum logic [3:0] {
    AmoNone = 4'h0,
    AmoSwap = 4'h1,
    AmoAdd  = 4'h2,
    AmoAnd  = 4'h3,
    AmoOr   = 4'h4,
    AmoXor  = 4'h5,
    AmoMax  = 4'h6,
    AmoMaxu = 4'h7,
    AmoMin  = 4'h8,
    AmoMinu = 4'h9,
    AmoLr   = 4'hA,
    AmoSc   = 4'hB
  } amo_op_e;

  typedef enum logic {
    Idle,
    AmoWrite
  } adapter_state_e;

  // True for the opcodes that need an in-bank read-modify-write.
  function automatic logic is_rmw_op(input logic [3:0] op);
    return (op >= AmoSwap) && (op <= AmoMinu);
  endfunction

endpackage

// File: rtl/spatz_amo_alu.sv
// Combinational AMO datapath: result = op(operand_a, operand_b), where
// operand_a is the old memory word and operand_b the request operand.
module spatz_amo_alu
  import spatz_tcdm_amo_adapter_pkg::*;
#(
  parameter int unsigned DataWidth = 32
) (
  input  logic [3:0]           op,
  input  logic [DataWidth-1:0] operand_a,
  input  logic [DataWidth-1:0] operand_b,
  output logic [DataWidth-1:0] result
);

  logic signed [DataWidth-1:0] a_s;
  logic signed [DataWidth-1:0] b_s;
  logic                        lt_s;
  logic                        lt_u;

  assign a_s  = $signed(operand_a);
  assign b_s  = $signed(operand_b);
  assign lt_s = a_s < b_s;
  assign lt_u = operand_a < operand_b;

  always_comb begin
    result = operand_b;
    case (op)
      AmoSwap: result = operand_b;
      AmoAdd:  result = operand_a + operand_b;
      AmoAnd:  result = operand_a & operand_b;
      AmoOr:   result = operand_a | operand_b;
      AmoXor:  result = operand_a ^ operand_b;
      AmoMax:  result = lt_s ? operand_b : operand_a;
      AmoMaxu: result = lt_u ? operand_b : operand_a;
      AmoMin:  result = lt_s ? operand_a : operand_b;
      AmoMinu: result = lt_u ? operand_a : operand_b;
      default: result = operand_b;
    endcase
  end

endmodule

// File: rtl/spatz_tcdm_amo_adapter.sv
// Per-bank TCDM adapter: fixed one-cycle response latency for loads/stores,
// in-bank read-modify-write for AMOs and a single LR/SC reservation.
module spatz_tcdm_amo_adapter
  import spatz_tcdm_amo_adapter_pkg::*;
#(
  parameter int unsigned AddrWidth = 10,
  parameter int unsigned DataWidth = 32,
  parameter int unsigned StrbWidth = DataWidth / 8
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 q_valid_i,
  output logic                 q_ready_o,
  input  logic [AddrWidth-1:0] q_addr_i,
  input  logic                 q_write_i,
  input  logic [3:0]           q_amo_i,
  input  logic [DataWidth-1:0] q_data_i,
  input  logic [StrbWidth-1:0] q_strb_i,
  output logic                 p_valid_o,
  output logic [DataWidth-1:0] p_data_o,
  output logic                 sram_req_o,
  output logic                 sram_we_o,
  output logic [AddrWidth-1:0] sram_addr_o,
  output logic [DataWidth-1:0] sram_wdata_o,
  output logic [StrbWidth-1:0] sram_be_o,
  input  logic [DataWidth-1:0] sram_rdata_i
);

  adapter_state_e state_q, state_d;

  logic                 rsv_vld_q;
  logic [AddrWidth-1:0] rsv_addr_q;

  logic [3:0]           amo_op_p1;
  logic [AddrWidth-1:0] amo_addr_p1;
  logic [DataWidth-1:0] amo_operand_p1;
  logic                 vld_p1;
  logic                 resp_sel_rdata_p1;
  logic [DataWidth-1:0] resp_data_p1;

  logic                 hs;
  logic                 is_rmw;
  logic                 is_lr;
  logic                 is_sc;
  logic                 is_store;
  logic                 rsv_hit;
  logic [DataWidth-1:0] alu_result;

  assign is_rmw   = is_rmw_op(q_amo_i);
  assign is_lr    = q_amo_i == AmoLr;
  assign is_sc    = q_amo_i == AmoSc;
  assign is_store = q_write_i && !is_rmw && !is_lr && !is_sc;
  assign rsv_hit  = rsv_vld_q && (rsv_addr_q == q_addr_i);
  assign hs       = q_valid_i && q_ready_o && !rst_i;

  spatz_amo_alu #(
    .DataWidth(DataWidth)
  ) i_amo_alu (
    .op       (amo_op_p1),
    .operand_a(sram_rdata_i),
    .operand_b(amo_operand_p1),
    .result   (alu_result)
  );

  always_comb begin
    state_d      = state_q;
    q_ready_o    = 1'b0;
    sram_req_o   = 1'b0;
    sram_we_o    = 1'b0;
    sram_addr_o  = '0;
    sram_wdata_o = '0;
    sram_be_o    = '0;
    case (state_q)
      Idle: begin
        q_ready_o    = 1'b1;
        sram_req_o   = q_valid_i;
        sram_addr_o  = q_addr_i;
        sram_wdata_o = q_data_i;
        sram_be_o    = '1;
        if (is_sc) begin
          sram_we_o = rsv_hit;
        end else if (is_store) begin
          sram_we_o = 1'b1;
          sram_be_o = q_strb_i;
        end
        if (hs && is_rmw) state_d = AmoWrite;
      end
      AmoWrite: begin
        sram_req_o   = 1'b1;
        sram_we_o    = 1'b1;
        sram_addr_o  = amo_addr_p1;
        sram_wdata_o = alu_result;
        sram_be_o    = '1;
        state_d      = Idle;
      end
      default: state_d = Idle;
    endcase
    // Reset must not let a half-finished AMO reach the bank.
    if (rst_i) begin
      sram_req_o   = 1'b0;
      sram_we_o    = 1'b0;
      sram_addr_o  = '0;
      sram_wdata_o = '0;
      sram_be_o    = '0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= Idle;
      rsv_vld_q <= 1'b0;
      vld_p1    <= 1'b0;
    end else begin
      state_q <= state_d;
      vld_p1  <= hs;
      if (hs) begin
        if (is_lr) begin
          rsv_vld_q <= 1'b1;
        end else if (is_sc) begin
          rsv_vld_q <= 1'b0;
        end else if ((is_rmw || is_store) && rsv_hit) begin
          rsv_vld_q <= 1'b0;
        end
      end
    end
  end

  // Request -> response stage: capture what the response cycle needs.
  always_ff @(posedge clk_i) begin
    if (hs) begin
      amo_op_p1         <= q_amo_i;
      amo_addr_p1       <= q_addr_i;
      amo_operand_p1    <= q_data_i;
      resp_sel_rdata_p1 <= !is_sc && !is_store;
      resp_data_p1      <= {{(DataWidth-1){1'b0}}, is_sc && !rsv_hit};
      if (is_lr) rsv_addr_q <= q_addr_i;
    end
  end

  assign p_valid_o = vld_p1 && !rst_i;
  assign p_data_o  = !p_valid_o        ? '0 :
                     resp_sel_rdata_p1 ? sram_rdata_i : resp_data_p1;

endmodule

// File: tb/tb_spatz_tcdm_amo_adapter.sv
// Directed bench for the TCDM AMO adapter with a behavioural one-cycle SRAM.
module tb_spatz_tcdm_amo_adapter;
  import spatz_tcdm_amo_adapter_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        q_valid;
  logic        q_ready;
  logic [9:0]  q_addr;
  logic        q_write;
  logic [3:0]  q_amo;
  logic [31:0] q_data;
  logic [3:0]  q_strb;
  logic        p_valid;
  logic [31:0] p_data;
  logic        sram_req;
  logic        sram_we;
  logic [9:0]  sram_addr;
  logic [31:0] sram_wdata;
  logic [3:0]  sram_be;
  logic [31:0] sram_rdata;

  logic [31:0] mem [0:1023];
  logic        bd_we;
  logic [9:0]  bd_addr;
  logic [31:0] bd_data;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  spatz_tcdm_amo_adapter dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .q_valid_i   (q_valid),
    .q_ready_o   (q_ready),
    .q_addr_i    (q_addr),
    .q_write_i   (q_write),
    .q_amo_i     (q_amo),
    .q_data_i    (q_data),
    .q_strb_i    (q_strb),
    .p_valid_o   (p_valid),
    .p_data_o    (p_data),
    .sram_req_o  (sram_req),
    .sram_we_o   (sram_we),
    .sram_addr_o (sram_addr),
    .sram_wdata_o(sram_wdata),
    .sram_be_o   (sram_be),
    .sram_rdata_i(sram_rdata)
  );

  always @(posedge clk) begin
    if (bd_we) begin
      mem[bd_addr] <= bd_data;
    end else if (sram_req) begin
      if (sram_we) begin
        for (int b = 0; b < 4; b++)
          if (sram_be[b]) mem[sram_addr][8*b +: 8] <= sram_wdata[8*b +: 8];
      end else begin
        sram_rdata <= mem[sram_addr];
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [9:0] a, input logic w,
                       input logic [3:0] op, input logic [31:0] d, input logic [3:0] s);
    q_valid = v; q_addr = a; q_write = w; q_amo = op; q_data = d; q_strb = s;
    #1;
  endtask

  task automatic bd_write(input logic [9:0] a, input logic [31:0] d);
    bd_we = 1'b1; bd_addr = a; bd_data = d;
    tick();
    bd_we = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    drive(1'b1, 10'd9, 1'b1, AmoNone, 32'h1, 4'hF);
    tests++; if (sram_req !== 1'b0 || sram_we !== 1'b0) begin fails++;
      $display("FAIL reset_sram: req=%b we=%b required 0 0", sram_req, sram_we); end
    tick(); tick();
    tests++; if (p_valid !== 1'b0 || p_data !== 32'h0) begin fails++;
      $display("FAIL reset_resp: valid=%b data=%h required 0 0", p_valid, p_data); end
    tests++; if (q_ready !== 1'b1) begin fails++;
      $display("FAIL reset_ready: got %b required 1", q_ready); end
    rst = 1'b0;
    drive(1'b0, 10'd0, 1'b0, AmoNone, 32'h0, 4'h0);
    tick();
    tests++; if (p_valid !== 1'b0) begin fails++;
      $display("FAIL reset_no_resp: valid=%b required 0", p_valid); end
  endtask

  task automatic test_read_write();
    drive(1'b1, 10'd5, 1'b1, AmoNone, 32'hDEADBEEF, 4'hF);
    tests++; if (q_ready !== 1'b1 || sram_we !== 1'b1) begin fails++;
      $display("FAIL wr_issue: ready=%b we=%b required 1 1", q_ready, sram_we); end
    tick();
    drive(1'b1, 10'd5, 1'b0, AmoNone, 32'h0, 4'h0);
    tests++; if (p_valid !== 1'b1 || p_data !== 32'h0) begin fails++;
      $display("FAIL wr_resp: valid=%b data=%h required 1 00000000", p_valid, p_data); end
    tests++; if (q_ready !== 1'b1) begin fails++;
      $display("FAIL wr_ready: got %b required 1", q_ready); end
    tick();
    drive(1'b0, 10'd0, 1'b0, AmoNone, 32'h0, 4'h0);
    tests++; if (p_valid !== 1'b1 || p_data !== 32'hDEADBEEF) begin fails++;
      $display("FAIL rd_resp: valid=%b data=%h required 1 deadbeef", p_valid, p_data); end
    tick();
    tests++; if (p_valid !== 1'b0 || p_data !== 32'h0) begin fails++;
      $display("FAIL rd_idle: valid=%b data=%h required 0 0", p_valid, p_data); end
    bd_write(10'd6, 32'hAAAAAAAA);
    drive(1'b1, 10'd6, 1'b1, AmoNone, 32'h11223344, 4'h5);
    tick();
    drive(1'b0, 10'd0, 1'b0, AmoNone, 32'h0, 4'h0);
    tests++; if (mem[6] !== 32'hAA22AA44) begin fails++;
      $display("FAIL wr_strb: mem=%h required aa22aa44", mem[6]); end
  endtask

  task automatic test_amo_add_hold();
    bd_write(10'd3, 32'd10);
    drive(1'b1, 10'd3, 1'b0, AmoAdd, 32'd5, 4'h0);
    tick();
    drive(1'b1, 10'd3, 1'b0, AmoNone, 32'h0, 4'h0);
    tests++; if (q_ready !== 1'b0) begin fails++;
      $display("FAIL amo_ready_low: got %b required 0", q_ready); end
    tests++; if (p_valid !== 1'b1 || p_data !== 32'd10) begin fails++;
      $display("FAIL amo_add_old: valid=%b data=%0d required 1 10", p_valid, p_data); end
    tests++; if (sram_we !== 1'b1 || sram_wdata !== 32'd15 || sram_addr !== 10'd3) begin fails++;
      $display("FAIL amo_add_wr: we=%b wdata=%0d addr=%0d required 1 15 3", sram_we, sram_wdata, sram_addr); end
    tick();
    tests++; if (q_ready !== 1'b1 || p_valid !== 1'b0) begin fails++;
      $display("FAIL amo_back_idle: ready=%b valid=%b required 1 0", q_ready, p_valid); end
    tests++; if (mem[3] !== 32'd15) begin fails++;
      $display("FAIL amo_add_mem: mem=%0d required 15", mem[3]); end
    tick();
    drive(1'b0, 10'd0, 1'b0, AmoNone, 32'h0, 4'h0);
    tests++; if (p_valid !== 1'b1 || p_data !== 32'd15) begin fails++;
      $display("FAIL amo_next_rd: valid=%b data=%0d required 1 15", p_valid, p_data); end
    tick();
  endtask

  task automatic run_amo(input logic [3:0] op, input logic [9:0] a, input logic [31:0] operand,
                         input logic [31:0] exp_old, input logic [31:0] exp_new);
    drive(1'b1, a, 1'b0, op, operand, 4'h0);
    tick();
    drive(1'b0, 10'd0, 1'b0, AmoNone, 32'h0, 4'h0);
    tests++; if (p_valid !== 1'b1 || p_data !== exp_old) begin fails++;
      $display("FAIL amo_old op=%0d: valid=%b data=%h required 1 %h", op, p_valid, p_data, exp_old); end
    tick();
    tests++; if (mem[a] !== exp_new) begin fails++;
      $display("FAIL amo_new op=%0d: mem=%h required %h", op, mem[a], exp_new); end
  endtask

  task automatic test_amo_ops();
    bd_write(10'd2, 32'hFFFFFFFF);
    run_amo(AmoMax, 10'd2, 32'd1, 32'hFFFFFFFF, 32'h00000001);
    bd_write(10'd2, 32'hFFFFFFFF);
    run_amo(AmoMaxu, 10'd2, 32'd1, 32'hFFFFFFFF, 32'hFFFFFFFF);
    bd_write(10'd2, 32'hFFFFFFFF);
    run_amo(AmoMin, 10'd2, 32'h80000000, 32'hFFFFFFFF, 32'h80000000);
    bd_write(10'd2, 32'd5);
    run_amo(AmoMinu, 10'd2, 32'hFFFFFFFF, 32'd5, 32'd5);
    bd_write(10'd2, 32'hFFFFFFFF);
    run_amo(AmoAdd, 10'd2, 32'd2, 32'hFFFFFFFF, 32'd1);
    bd_write(10'd2, 32'hF0F0F0F0);
    run_amo(AmoXor, 10'd2, 32'hFF00FF00, 32'hF0F0F0F0, 32'h0FF00FF0);
    run_amo(AmoSwap, 10'd2, 32'h12345678, 32'h0FF00FF0, 32'h12345678);
  endtask

  task automatic test_back_to_back();
    bd_write(10'd4, 32'd1);
    drive(1'b1, 10'd4, 1'b0, AmoAdd, 32'd2, 4'h0);
    tick();
    drive(1'b1, 10'd4, 1'b0, AmoAdd, 32'd3, 4'h0);
    tests++; if (p_data !== 32'd1) begin fails++;
      $display("FAIL b2b_first: data=%0d required 1", p_data); end
    tick(); tick();
    drive(1'b0, 10'd0, 1'b0, AmoNone, 32'h0, 4'h0);
    tests++; if (p_valid !== 1'b1 || p_data !== 32'd3) begin fails++;
      $display("FAIL b2b_second: valid=%b data=%0d required 1 3", p_valid, p_data); end
    tick();
    tests++; if (mem[4] !== 32'd6) begin fails++;
      $display("FAIL b2b_mem: mem=%0d required 6", mem[4]); end
  endtask

  task automatic test_lr_sc();
    bd_write(10'd7, 32'h00001234);
    drive(1'b1, 10'd7, 1'b0, AmoLr, 32'h0, 4'h0);
    tick();
    drive(1'b1, 10'd7, 1'b0, AmoSc, 32'h55, 4'h0);
    tests++; if (p_valid !== 1'b1 || p_data !== 32'h1234) begin fails++;
      $display("FAIL lr_data: valid=%b data=%h required 1 00001234", p_valid, p_data); end
    tick();
    drive(1'b1, 10'd7, 1'b0, AmoSc, 32'h66, 4'h0);
    tests++; if (p_valid !== 1'b1 || p_data !== 32'd0) begin fails++;
      $display("FAIL sc_ok: valid=%b data=%0d required 1 0", p_valid, p_data); end
    tests++; if (mem[7] !== 32'h55) begin fails++;
      $display("FAIL sc_ok_mem: mem=%h required 00000055", mem[7]); end
    tick();
    drive(1'b0, 10'd0, 1'b0, AmoNone, 32'h0, 4'h0);
    tests++; if (p_valid !== 1'b1 || p_data !== 32'd1) begin fails++;
      $display("FAIL sc_again: valid=%b data=%0d required 1 1", p_valid, p_data); end
    tick();
    tests++; if (mem[7] !== 32'h55) begin fails++;
      $display("FAIL sc_again_mem: mem=%h required 00000055", mem[7]); end
    drive(1'b1, 10'd7, 1'b0, AmoLr, 32'h0, 4'h0);
    tick();
    drive(1'b1, 10'd7, 1'b1, AmoNone, 32'h77, 4'hF);
    tick();
    drive(1'b1, 10'd7, 1'b0, AmoSc, 32'h88, 4'h0);
    tick();
    drive(1'b0, 10'd0, 1'b0, AmoNone, 32'h0, 4'h0);
    tests++; if (p_valid !== 1'b1 || p_data !== 32'd1) begin fails++;
      $display("FAIL sc_after_st: valid=%b data=%0d required 1 1", p_valid, p_data); end
    tick();
    tests++; if (mem[7] !== 32'h77) begin fails++;
      $display("FAIL sc_after_st_mem: mem=%h required 00000077", mem[7]); end
  endtask

  task automatic test_reset_in_amo();
    bd_write(10'd1, 32'h0000CAFE);
    drive(1'b1, 10'd1, 1'b0, AmoSwap, 32'h0000BEEF, 4'h0);
    tick();
    rst = 1'b1;
    drive(1'b0, 10'd0, 1'b0, AmoNone, 32'h0, 4'h0);
    tests++; if (sram_req !== 1'b0 || sram_we !== 1'b0 || p_valid !== 1'b0) begin fails++;
      $display("FAIL rst_amo_out: req=%b we=%b valid=%b required 0 0 0", sram_req, sram_we, p_valid); end
    tick();
    rst = 1'b0;
    #1;
    tests++; if (q_ready !== 1'b1 || p_valid !== 1'b0) begin fails++;
      $display("FAIL rst_amo_idle: ready=%b valid=%b required 1 0", q_ready, p_valid); end
    tests++; if (mem[1] !== 32'h0000CAFE) begin fails++;
      $display("FAIL rst_amo_mem: mem=%h required 0000cafe", mem[1]); end
  endtask

  initial begin
    bd_we = 1'b0; bd_addr = '0; bd_data = '0;
    sram_rdata = '0;
    q_valid = 1'b0; q_addr = '0; q_write = 1'b0; q_amo = AmoNone; q_data = '0; q_strb = '0;
    rst = 1'b1;
    test_reset();
    test_read_write();
    test_amo_add_hold();
    test_amo_ops();
    test_back_to_back();
    test_lr_sc();
    test_reset_in_amo();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
